// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage pipeline: load-use/branch stall and flush,
// operand forwarding, and a wait-state FSM that freezes the pipe on slow data memory.
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RsE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       WriteReg_E,
  input  logic [4:0]       WriteReg_M,
  input  logic [4:0]       WriteReg_W,
  input  logic             RegWrite_E,
  input  logic             RegWrite_M,
  input  logic             RegWrite_W,
  input  logic             MemToReg_E,
  input  logic             MemToReg_M,
  input  logic             Branch_D,
  input  logic             MemRead_M,
  input  logic             MemWrite_M,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic access_s;
  logic mem_stall_s;
  logic lwstall_s;
  logic brstall_s;
  logic stall_front_s;

  // Memory wait-state sequencing and the resulting pipeline freeze.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    mem_req     = 1'b0;
    mem_stall_s = 1'b0;
    access_s    = MemRead_M | MemWrite_M;
    case (state_q)
      S_IDLE: begin
        mem_req = access_s;
        if (access_s && !mem_ack) begin
          mem_stall_s = 1'b1;
          state_d     = S_WAIT;
          timer_d     = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          state_d = S_IDLE;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          mem_stall_s = 1'b1;
          state_d     = S_ERR;
        end else begin
          mem_stall_s = 1'b1;
          timer_d     = timer_q + TW'(1);
        end
      end
      S_ERR: begin
        mem_stall_s = 1'b1;
        state_d     = S_ERR;
      end
      default: begin
        // An unreachable encoding is treated as a fault and frozen.
        mem_stall_s = 1'b1;
        state_d     = S_ERR;
      end
    endcase
  end

  // Data hazards, stall/flush fan-out and forwarding selects.
  always_comb begin
    lwstall_s = MemToReg_E && (RtE != 5'd0) && ((RtE == RsD) || (RtE == RtD));
    brstall_s = Branch_D &&
                ((RegWrite_E && (WriteReg_E != 5'd0) &&
                  ((WriteReg_E == RsD) || (WriteReg_E == RtD))) ||
                 (MemToReg_M && (WriteReg_M != 5'd0) &&
                  ((WriteReg_M == RsD) || (WriteReg_M == RtD))));
    stall_front_s = mem_stall_s | lwstall_s | brstall_s;

    StallF = stall_front_s;
    StallD = stall_front_s;
    StallE = mem_stall_s;
    StallM = mem_stall_s;
    FlushW = mem_stall_s;
    FlushE = (lwstall_s | brstall_s) & ~mem_stall_s;

    if ((RsE != 5'd0) && RegWrite_M && (WriteReg_M == RsE)) begin
      ForwardAE = 2'b10;
    end else if ((RsE != 5'd0) && RegWrite_W && (WriteReg_W == RsE)) begin
      ForwardAE = 2'b01;
    end else begin
      ForwardAE = 2'b00;
    end

    if ((RtE != 5'd0) && RegWrite_M && (WriteReg_M == RtE)) begin
      ForwardBE = 2'b10;
    end else if ((RtE != 5'd0) && RegWrite_W && (WriteReg_W == RtE)) begin
      ForwardBE = 2'b01;
    end else begin
      ForwardBE = 2'b00;
    end

    ForwardAD = RegWrite_M && (WriteReg_M != 5'd0) && (WriteReg_M == RsD);
    ForwardBD = RegWrite_M && (WriteReg_M != 5'd0) && (WriteReg_M == RtD);
  end

  // Sticky timeout flag and saturating front-end stall counter.
  always_comb begin
    mem_timeout_d = mem_timeout_q | (state_d == S_ERR);
    if (stall_front_s && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end else begin
      stall_count_d = stall_count_q;
    end
    mem_timeout = mem_timeout_q;
    stall_count = stall_count_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      mem_timeout_q <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      mem_timeout_q <= mem_timeout_d;
      stall_count_q <= stall_count_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed vectors, an abstract per-cycle model
// checked on every falling edge, and literal expectations pinning the key scenarios.
module tb_pipeline_hazard_ctrl;

  localparam int TO      = 4;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] RsD, RtD, RsE, RtE, WriteReg_E, WriteReg_M, WriteReg_W;
  logic RegWrite_E, RegWrite_M, RegWrite_W, MemToReg_E, MemToReg_M, Branch_D;
  logic MemRead_M, MemWrite_M, mem_ack;
  logic mem_req, StallF, StallD, StallE, StallM, FlushE, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic ForwardAD, ForwardBD, mem_timeout;
  logic [CW-1:0] stall_count;

  int checks   = 0;
  int failures = 0;

  // model state: waiting on memory, WAIT cycles elapsed, timed out, stall cycles seen
  bit m_valid  = 1'b0;
  bit m_wait   = 1'b0;
  bit m_err    = 1'b0;
  int m_waited = 0;
  int m_cnt    = 0;

  pipeline_hazard_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteReg_E(WriteReg_E), .WriteReg_M(WriteReg_M), .WriteReg_W(WriteReg_W),
    .RegWrite_E(RegWrite_E), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
    .MemToReg_E(MemToReg_E), .MemToReg_M(MemToReg_M), .Branch_D(Branch_D),
    .MemRead_M(MemRead_M), .MemWrite_M(MemWrite_M), .mem_ack(mem_ack),
    .mem_req(mem_req), .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushE(FlushE), .FlushW(FlushW), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .mem_timeout(mem_timeout),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit dest_hits(input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
    return (d != 5'd0) && ((d == a) || (d == b));
  endfunction

  function automatic int fwd_e(input logic [4:0] src);
    if (src == 5'd0) return 0;
    if (RegWrite_M && WriteReg_M == src) return 2;
    if (RegWrite_W && WriteReg_W == src) return 1;
    return 0;
  endfunction

  function automatic bit e_access();
    return MemRead_M || MemWrite_M;
  endfunction

  function automatic bit e_memstall();
    return m_err || (m_wait && !mem_ack) || (!m_wait && e_access() && !mem_ack);
  endfunction

  function automatic bit e_hazard();
    bit lw, br;
    lw = MemToReg_E && dest_hits(RtE, RsD, RtD);
    br = Branch_D && ((RegWrite_E && dest_hits(WriteReg_E, RsD, RtD)) ||
                      (MemToReg_M && dest_hits(WriteReg_M, RsD, RtD)));
    return lw || br;
  endfunction

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_mem_req",  mem_req,  !m_err && (m_wait || e_access()));
      chk("m_StallF",   StallF,   e_memstall() || e_hazard());
      chk("m_StallD",   StallD,   e_memstall() || e_hazard());
      chk("m_StallE",   StallE,   e_memstall());
      chk("m_StallM",   StallM,   e_memstall());
      chk("m_FlushW",   FlushW,   e_memstall());
      chk("m_FlushE",   FlushE,   e_hazard() && !e_memstall());
      chk("m_ForwardAE", ForwardAE, fwd_e(RsE));
      chk("m_ForwardBE", ForwardBE, fwd_e(RtE));
      chk("m_ForwardAD", ForwardAD, RegWrite_M && WriteReg_M != 5'd0 && WriteReg_M == RsD);
      chk("m_ForwardBD", ForwardBD, RegWrite_M && WriteReg_M != 5'd0 && WriteReg_M == RtD);
      chk("m_mem_timeout", mem_timeout, m_err);
      chk("m_stall_count", stall_count, m_cnt);
    end
  end

  // model advance at each rising edge
  always @(posedge clk) begin
    if (reset) begin
      m_valid  <= 1'b1;
      m_wait   <= 1'b0;
      m_err    <= 1'b0;
      m_waited <= 0;
      m_cnt    <= 0;
    end else begin
      if ((e_memstall() || e_hazard()) && m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
      if (!m_err && m_wait && !mem_ack) begin
        m_waited <= m_waited + 1;
        if (m_waited + 1 == TO) begin
          m_err  <= 1'b1;
          m_wait <= 1'b0;
        end
      end else if (!m_err && m_wait) begin
        m_wait <= 1'b0;
      end else if (!m_err && e_access() && !mem_ack) begin
        m_wait   <= 1'b1;
        m_waited <= 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    RsD = 5'd0; RtD = 5'd0; RsE = 5'd0; RtE = 5'd0;
    WriteReg_E = 5'd0; WriteReg_M = 5'd0; WriteReg_W = 5'd0;
    RegWrite_E = 1'b0; RegWrite_M = 1'b0; RegWrite_W = 1'b0;
    MemToReg_E = 1'b0; MemToReg_M = 1'b0; Branch_D = 1'b0;
    MemRead_M = 1'b0; MemWrite_M = 1'b0; mem_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_StallF", StallF, 1'b0);
    chk("rst_count", stall_count, 4'd0);
    chk("rst_timeout", mem_timeout, 1'b0);

    // forwarding: M beats W, reg 0 never forwarded
    tick();
    RegWrite_M = 1'b1; WriteReg_M = 5'd5; RegWrite_W = 1'b1; WriteReg_W = 5'd5; RsE = 5'd5;
    @(negedge clk);
    chk("fwd_m_wins", ForwardAE, 2'b10);
    tick();
    RsE = 5'd0;
    @(negedge clk);
    chk("fwd_r0", ForwardAE, 2'b00);
    tick();
    RsE = 5'd5; RtE = 5'd5; RegWrite_M = 1'b0; RsD = 5'd5;
    @(negedge clk);
    chk("fwd_w_only", ForwardAE, 2'b01);
    chk("fwd_w_only_b", ForwardBE, 2'b01);
    chk("fwd_ad_off", ForwardAD, 1'b0);
    tick();
    RegWrite_M = 1'b1; WriteReg_M = 5'd7; RtD = 5'd7; RsD = 5'd3; WriteReg_W = 5'd9;
    @(negedge clk);
    chk("fwd_bd", ForwardBD, 1'b1);
    chk("fwd_ad", ForwardAD, 1'b0);

    // load-use stall
    tick();
    idle_inputs();
    MemToReg_E = 1'b1; RtE = 5'd8; RsD = 5'd8;
    @(negedge clk);
    chk("lw_StallF", StallF, 1'b1);
    chk("lw_FlushE", FlushE, 1'b1);
    chk("lw_StallE", StallE, 1'b0);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("lw_count", stall_count, 4'd1);

    // branch hazards, including the r0 exclusion
    tick();
    Branch_D = 1'b1; RegWrite_E = 1'b1; WriteReg_E = 5'd3; RtD = 5'd3;
    @(negedge clk);
    chk("br_E_FlushE", FlushE, 1'b1);
    tick();
    RegWrite_E = 1'b0; MemToReg_M = 1'b1; WriteReg_M = 5'd4; RsD = 5'd4;
    @(negedge clk);
    chk("br_M_StallD", StallD, 1'b1);
    tick();
    WriteReg_M = 5'd0; RsD = 5'd0; RegWrite_E = 1'b1; WriteReg_E = 5'd0; RtD = 5'd0;
    @(negedge clk);
    chk("br_r0_StallF", StallF, 1'b0);

    // read with three wait cycles
    tick();
    idle_inputs();
    MemRead_M = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rd_wait_req", mem_req, 1'b1);
      chk("rd_wait_StallM", StallM, 1'b1);
      chk("rd_wait_FlushW", FlushW, 1'b1);
      tick();
    end
    mem_ack = 1'b1;
    @(negedge clk);
    chk("rd_ack_req", mem_req, 1'b1);
    chk("rd_ack_StallF", StallF, 1'b0);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("rd_done_req", mem_req, 1'b0);

    // write acknowledged immediately
    tick();
    MemWrite_M = 1'b1; mem_ack = 1'b1;
    @(negedge clk);
    chk("wr_req", mem_req, 1'b1);
    chk("wr_StallM", StallM, 1'b0);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("wr_idle_req", mem_req, 1'b0);

    // load-use during WAIT, then reset mid-WAIT
    tick();
    MemRead_M = 1'b1;
    tick();
    MemToReg_E = 1'b1; RtE = 5'd8; RsD = 5'd8;
    @(negedge clk);
    chk("lwwait_FlushE", FlushE, 1'b0);
    chk("lwwait_StallE", StallE, 1'b1);
    chk("lwwait_StallF", StallF, 1'b1);
    tick();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rstwait_req", mem_req, 1'b0);
    chk("rstwait_StallF", StallF, 1'b0);

    // timeout: one IDLE stall cycle, four WAIT cycles, then ERR
    tick();
    MemRead_M = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    @(negedge clk);
    chk("to_last_wait_req", mem_req, 1'b1);
    chk("to_last_wait_flag", mem_timeout, 1'b0);
    tick();
    @(negedge clk);
    chk("to_err_flag", mem_timeout, 1'b1);
    chk("to_err_req", mem_req, 1'b0);
    chk("to_err_StallM", StallM, 1'b1);
    tick();
    MemRead_M = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    @(negedge clk);
    chk("to_sticky", mem_timeout, 1'b1);
    chk("cnt_saturate", stall_count, 4'hF);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("to_rst_flag", mem_timeout, 1'b0);
    chk("to_rst_count", stall_count, 4'd0);
    chk("to_rst_StallF", StallF, 1'b0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
